// File: rtl/mgmt_spi_regbank.sv
// mgmt_spi_regbank: SPI opcode/address/data bridge exposing a per-transaction
// sensor snapshot, a channel-count/transaction-counter pair and a control byte bank.
module mgmt_spi_regbank #(
   parameter int NUM_CHANNELS  = 8,
   parameter int CHANNEL_WIDTH = 16,
   parameter int NUM_CTRL      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  spi_cs_n,
   input  logic                                  spi_cs_falling,
   input  logic                                  spi_rx_data_valid,
   input  logic [7:0]                            spi_rx_data,
   output logic                                  spi_tx_data_valid,
   output logic [7:0]                            spi_tx_data,
   input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] ch_data,
   output logic [NUM_CTRL*8-1:0]                 ctrl_out,
   output logic                                  ctrl_wr_en,
   output logic [5:0]                            ctrl_wr_idx,
   output logic                                  busy
);
   typedef enum logic [2:0] {IDLE, OPCODE, RADDR, READ, WADDR, WRITE, DISCARD} state_t;
   state_t state;
   logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] snap;
   logic [31:0] snap_w [NUM_CHANNELS];
   logic [7:0] ptr, cnt, raddr;
   assign busy  = state != IDLE;
   assign raddr = state == RADDR ? spi_rx_data : ptr;
   always_comb
      for (int i = 0; i < NUM_CHANNELS; i++)
         snap_w[i] = 32'(snap[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
   // Unmapped addresses fall through to 0xFF.
   function automatic logic [7:0] map_rd(input logic [7:0] a);
      logic [7:0] r;
      r = a == 8'h7E ? 8'(NUM_CHANNELS) : a == 8'h7F ? cnt : 8'hFF;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (a[7:2] == 6'(i)) r = snap_w[i][{a[1:0], 3'b000} +: 8];
      for (int k = 0; k < NUM_CTRL; k++)
         if (a == 8'(8'h80 + k)) r = ctrl_out[k*8 +: 8];
      return r;
   endfunction
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state             <= IDLE;
         snap              <= '0;
         ptr               <= '0;
         cnt               <= '0;
         ctrl_out          <= '0;
         spi_tx_data_valid <= 1'b0;
         spi_tx_data       <= '0;
         ctrl_wr_en        <= 1'b0;
         ctrl_wr_idx       <= '0;
      end else begin
         spi_tx_data_valid <= 1'b0;
         ctrl_wr_en        <= 1'b0;
         if (spi_cs_falling) begin
            state <= OPCODE;
            snap  <= ch_data;
            cnt   <= cnt + 8'd1;
         end else if (spi_cs_n) begin
            state <= IDLE;
         end else if (spi_rx_data_valid) begin
            case (state)
               OPCODE: state <= spi_rx_data == 8'h01 ? RADDR : spi_rx_data == 8'h02 ? WADDR : DISCARD;
               RADDR, READ: begin
                  state             <= READ;
                  spi_tx_data_valid <= 1'b1;
                  spi_tx_data       <= map_rd(raddr);
                  ptr               <= raddr + 8'd1;
               end
               WADDR: begin
                  state <= WRITE;
                  ptr   <= spi_rx_data;
               end
               WRITE: begin
                  ptr <= ptr + 8'd1;
                  for (int k = 0; k < NUM_CTRL; k++)
                     if (ptr == 8'(8'h80 + k)) begin
                        ctrl_out[k*8 +: 8] <= spi_rx_data;
                        ctrl_wr_en         <= 1'b1;
                        ctrl_wr_idx        <= 6'(k);
                     end
               end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_mgmt_spi_regbank.sv
// tb_mgmt_spi_regbank: directed and randomized SPI transactions checked
// against an address-map model of the register bank.
module tb_mgmt_spi_regbank;
   localparam int NC = 8, CW = 16, NK = 4;
   logic clk = 0, rst_n = 0, spi_cs_n = 1, spi_cs_falling = 0, spi_rx_data_valid = 0;
   logic [7:0] spi_rx_data = 0;
   logic spi_tx_data_valid, ctrl_wr_en, busy;
   logic [7:0] spi_tx_data;
   logic [NC*CW-1:0] ch_data = '0;
   logic [NK*8-1:0] ctrl_out;
   logic [5:0] ctrl_wr_idx;
   int checks = 0, failures = 0;
   int m_snap [NC];
   int m_ctrl [NK];
   int m_cnt = 0;

   mgmt_spi_regbank #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .NUM_CTRL(NK)) dut (
      .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_cs_falling(spi_cs_falling),
      .spi_rx_data_valid(spi_rx_data_valid), .spi_rx_data(spi_rx_data),
      .spi_tx_data_valid(spi_tx_data_valid), .spi_tx_data(spi_tx_data), .ch_data(ch_data),
      .ctrl_out(ctrl_out), .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_idx(ctrl_wr_idx), .busy(busy));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int mmap(input int a);
      if (a < 4*NC) return (m_snap[a/4] >> (8*(a%4))) & 255;
      if (a == 126) return NC;
      if (a == 127) return m_cnt;
      if (a >= 128 && a < 128 + NK) return m_ctrl[a-128];
      return 255;
   endfunction

   function automatic logic [NK*8-1:0] mctrl();
      logic [NK*8-1:0] v;
      for (int k = 0; k < NK; k++) v[k*8 +: 8] = 8'(m_ctrl[k]);
      return v;
   endfunction

   function automatic void mreset();
      m_cnt = 0;
      for (int i = 0; i < NC; i++) m_snap[i] = 0;
      for (int k = 0; k < NK; k++) m_ctrl[k] = 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ch();
      for (int i = 0; i < NC; i++) ch_data[i*CW +: CW] = CW'($urandom);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_txv"}, spi_tx_data_valid, 0);
      check({tag, "_txd"}, spi_tx_data, 0);
      check({tag, "_ctrl"}, ctrl_out, 0);
      check({tag, "_wren"}, ctrl_wr_en, 0);
      check({tag, "_idx"}, ctrl_wr_idx, 0);
   endtask

   task automatic start(input logic [7:0] rx = 8'h00, input bit with_rx = 0);
      spi_cs_n = 0;
      spi_cs_falling = 1;
      spi_rx_data_valid = with_rx;
      spi_rx_data = rx;
      for (int i = 0; i < NC; i++) m_snap[i] = int'(ch_data[i*CW +: CW]);
      m_cnt = (m_cnt + 1) % 256;
      tick();
      spi_cs_falling = 0;
      spi_rx_data_valid = 0;
      check("busy_start", busy, 1);
      check("txv_start", spi_tx_data_valid, 0);
   endtask

   task automatic stop();
      spi_cs_n = 1;
      tick();
      check("busy_stop", busy, 0);
      check("ctrl_hold", ctrl_out, mctrl());
   endtask

   task automatic send(input logic [7:0] b, input int etx, input int ewr);
      spi_rx_data_valid = 1;
      spi_rx_data = b;
      tick();
      spi_rx_data_valid = 0;
      check("tx_valid", spi_tx_data_valid, etx >= 0);
      if (etx >= 0) check("tx_data", spi_tx_data, etx);
      check("wr_en", ctrl_wr_en, ewr >= 0);
      if (ewr >= 0) check("wr_idx", ctrl_wr_idx, ewr);
      repeat ($urandom_range(0, 2)) begin
         tick();
         check("tx_quiet", spi_tx_data_valid, 0);
         check("wr_quiet", ctrl_wr_en, 0);
      end
   endtask

   task automatic rd(input int a, input int n);
      start();
      send(8'h01, -1, -1);
      for (int i = 0; i < n; i++) begin
         send(i == 0 ? 8'(a) : 8'($urandom), mmap((a + i) % 256), -1);
         rand_ch();
      end
      stop();
   endtask

   task automatic wr(input int a, input int n, input logic [63:0] d);
      start();
      send(8'h02, -1, -1);
      send(8'(a), -1, -1);
      for (int i = 0; i < n; i++) begin
         int p;
         p = (a + i) % 256;
         if (p >= 128 && p < 128 + NK) begin
            m_ctrl[p-128] = int'(d[i*8 +: 8]);
            send(d[i*8 +: 8], -1, p - 128);
         end else send(d[i*8 +: 8], -1, -1);
      end
      stop();
      check("ctrl_after_wr", ctrl_out, mctrl());
   endtask

   initial begin
      mreset();
      tick();
      check_zero("reset");
      rst_n = 1;
      tick();
      rand_ch();
      ch_data[15:0] = 16'hBEEF;
      rd(0, 3);
      rd(4, 4);
      rd(4, 4);
      wr(8'h81, 2, 64'h5AA5);
      rd(8'h81, 2);
      rd(8'h7E, 3);
      rd(8'hFF, 2);
      wr(8'h10, 2, 64'h3344);
      // abort mid-write, then a stray byte with chip select high
      start();
      send(8'h02, -1, -1);
      send(8'h80, -1, -1);
      m_ctrl[0] = 8'h77;
      send(8'h77, -1, 0);
      spi_cs_n = 1;
      tick();
      check("abort_busy", busy, 0);
      send(8'h99, -1, -1);
      check("abort_ctrl", ctrl_out, mctrl());
      // re-sync during READ
      start();
      send(8'h01, -1, -1);
      send(8'h7F, mmap(127), -1);
      start();
      send(8'h01, -1, -1);
      send(8'h7F, mmap(127), -1);
      stop();
      // cs_falling together with rx valid: byte 0x02 must be dropped
      start();
      send(8'h01, -1, -1);
      send(8'h00, mmap(0), -1);
      start(8'h02, 1);
      send(8'h01, -1, -1);
      send(8'h7F, mmap(127), -1);
      stop();
      // bad opcode
      start();
      send(8'h33, -1, -1);
      send(8'h81, -1, -1);
      send(8'h55, -1, -1);
      stop();
      for (int t = 0; t < 40; t++) begin
         int a;
         a = ($urandom % 2) ? $urandom_range(0, 255) : $urandom_range(8'h7C, 8'h84);
         rand_ch();
         if ($urandom % 2) rd(a, $urandom_range(1, 6));
         else wr(a, $urandom_range(1, 6), {$urandom, $urandom});
      end
      // async reset mid-read
      start();
      send(8'h01, -1, -1);
      send(8'h7F, mmap(127), -1);
      rst_n = 0;
      #1;
      check_zero("rst_mid");
      spi_cs_n = 1;
      tick();
      rst_n = 1;
      mreset();
      tick();
      rd(8'h7F, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
